// File: rtl/uart_word_bridge_if.sv
// Stream and status bundle between the byte-wide UART core, the word-wide processor and the bridge.
// The bridge connects to the slave modport; the surrounding environment connects to the master modport.
interface uart_word_bridge_if #(
  parameter int INP_WIDTH  = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  // Every *_tvalid/*_tready pair: a beat transfers on a rising clk edge where both are high;
  // once valid is raised, data stays stable and valid stays high until that transfer.
  logic [BYTE_WIDTH-1:0] rx_tdata;
  logic                  rx_tvalid;
  logic                  rx_tready;
  logic                  rx_frame_error;
  logic                  rx_overrun_error;
  logic [INP_WIDTH-1:0]  inp_tdata;
  logic                  inp_tvalid;
  logic                  inp_tready;
  logic [OUT_WIDTH-1:0]  out_tdata;
  logic                  out_tvalid;
  logic                  out_tready;
  logic [BYTE_WIDTH-1:0] tx_tdata;
  logic                  tx_tvalid;
  logic                  tx_tready;
  logic                  err_clear;
  logic                  rx_error;
  logic                  timeout_error;
  logic [CNT_WIDTH-1:0]  drop_count;
  logic [1:0]            dbg_rx_state;
  logic [1:0]            dbg_tx_state;

  modport master (
    output rx_tdata, rx_tvalid, rx_frame_error, rx_overrun_error, inp_tready,
           out_tdata, out_tvalid, tx_tready, err_clear,
    input  rx_tready, inp_tdata, inp_tvalid, out_tready, tx_tdata, tx_tvalid,
           rx_error, timeout_error, drop_count, dbg_rx_state, dbg_tx_state
  );

  modport slave (
    input  rx_tdata, rx_tvalid, rx_frame_error, rx_overrun_error, inp_tready,
           out_tdata, out_tvalid, tx_tready, err_clear,
    output rx_tready, inp_tdata, inp_tvalid, out_tready, tx_tdata, tx_tvalid,
           rx_error, timeout_error, drop_count, dbg_rx_state, dbg_tx_state
  );
endinterface

// File: rtl/uart_word_bridge.sv
// Byte-to-word (RX) and word-to-byte (TX) bridge between a UART core and the word processor,
// with byte-order selection, stale-partial-word timeout, error resync and sticky status.
module uart_word_bridge #(
  parameter int INP_WIDTH      = 24,
  parameter int OUT_WIDTH      = 16,
  parameter int BYTE_WIDTH     = 8,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_WIDTH      = 16
) (
  input logic               clk,
  input logic               arstn,
  uart_word_bridge_if.slave bus
);
  localparam int NI    = (INP_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
  localparam int NO    = (OUT_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
  localparam int IDX_W = (NI > 1) ? $clog2(NI) : 1;
  localparam int ODX_W = (NO > 1) ? $clog2(NO) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NI - 1);
  localparam logic [ODX_W-1:0] ODX_LAST = ODX_W'(NO - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_HOLD} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  rx_state_e             rx_state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [INP_WIDTH-1:0]  word_q;
  logic                  inp_tvalid_q;
  logic                  rx_tready_q;

  tx_state_e             tx_state_q;
  logic [ODX_W-1:0]      odx_q;
  logic [OUT_WIDTH-1:0]  tx_word_q;
  logic [BYTE_WIDTH-1:0] tx_tdata_q;
  logic                  tx_tvalid_q;
  logic                  out_tready_q;

  logic                  rx_error_q, rx_error_d;
  logic                  timeout_error_q, timeout_error_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic                  rx_acc, rx_err, rx_discard, tmo_fire;
  logic [IDX_W-1:0]      rx_lane;
  logic [INP_WIDTH-1:0]  word_ins;

  // Byte lane `o` of the word counted in wire order; bits above OUT_WIDTH read as zero.
  function automatic logic [BYTE_WIDTH-1:0] tx_byte(input logic [OUT_WIDTH-1:0] w,
                                                    input logic [ODX_W-1:0] o);
    logic [ODX_W-1:0] lane;
    tx_byte = '0;
    lane = (MSB_FIRST != 0) ? (ODX_LAST - o) : o;
    for (int b = 0; b < OUT_WIDTH; b++) begin
      if (ODX_W'(b / BYTE_WIDTH) == lane) tx_byte[b % BYTE_WIDTH] = w[b];
    end
  endfunction

  always_comb begin
    rx_acc     = bus.rx_tvalid && rx_tready_q;
    rx_err     = bus.rx_frame_error || bus.rx_overrun_error;
    rx_discard = rx_err && ((rx_state_q == RX_COLLECT) || ((rx_state_q == RX_IDLE) && rx_acc));
    tmo_fire   = (TIMEOUT_CYCLES != 0) && (rx_state_q == RX_COLLECT) && !rx_acc && !rx_err &&
                 (tmo_q == TMO_LAST);
    rx_lane    = (MSB_FIRST != 0) ? (IDX_LAST - idx_q) : idx_q;
    word_ins   = word_q;
    for (int b = 0; b < INP_WIDTH; b++) begin
      if (IDX_W'(b / BYTE_WIDTH) == rx_lane) word_ins[b] = bus.rx_tdata[b % BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_state_q   <= RX_IDLE;
      idx_q        <= '0;
      tmo_q        <= '0;
      word_q       <= '0;
      inp_tvalid_q <= 1'b0;
      rx_tready_q  <= 1'b1;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_acc && rx_discard) begin
            word_q <= '0;
            idx_q  <= '0;
          end else if (rx_acc) begin
            word_q <= word_ins;
            tmo_q  <= '0;
            if (NI == 1) begin
              rx_state_q   <= RX_HOLD;
              inp_tvalid_q <= 1'b1;
              rx_tready_q  <= 1'b0;
            end else begin
              rx_state_q <= RX_COLLECT;
              idx_q      <= idx_q + 1'b1;
            end
          end
        end
        RX_COLLECT: begin
          if (rx_discard || tmo_fire) begin
            word_q     <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            rx_state_q <= RX_IDLE;
          end else if (rx_acc) begin
            word_q <= word_ins;
            tmo_q  <= '0;
            if (idx_q == IDX_LAST) begin
              rx_state_q   <= RX_HOLD;
              idx_q        <= '0;
              inp_tvalid_q <= 1'b1;
              rx_tready_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RX_HOLD: begin
          if (bus.inp_tready) begin
            rx_state_q   <= RX_IDLE;
            inp_tvalid_q <= 1'b0;
            rx_tready_q  <= 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_state_q   <= TX_IDLE;
      odx_q        <= '0;
      tx_word_q    <= '0;
      tx_tdata_q   <= '0;
      tx_tvalid_q  <= 1'b0;
      out_tready_q <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (bus.out_tvalid && out_tready_q) begin
            tx_word_q    <= bus.out_tdata;
            odx_q        <= '0;
            tx_tdata_q   <= tx_byte(bus.out_tdata, '0);
            tx_tvalid_q  <= 1'b1;
            out_tready_q <= 1'b0;
            tx_state_q   <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (bus.tx_tready) begin
            if (odx_q == ODX_LAST) begin
              odx_q        <= '0;
              tx_tvalid_q  <= 1'b0;
              out_tready_q <= 1'b1;
              tx_state_q   <= TX_IDLE;
            end else begin
              odx_q      <= odx_q + 1'b1;
              tx_tdata_q <= tx_byte(tx_word_q, odx_q + 1'b1);
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // A set/increment event in the same cycle as err_clear survives the clear.
  always_comb begin
    rx_error_d      = bus.err_clear ? rx_err   : (rx_error_q || rx_err);
    timeout_error_d = bus.err_clear ? tmo_fire : (timeout_error_q || tmo_fire);
    drop_count_d    = bus.err_clear ? '0 : drop_count_q;
    if (rx_discard || tmo_fire) begin
      if (bus.err_clear)           drop_count_d = CNT_WIDTH'(1);
      else if (drop_count_q != '1) drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_error_q      <= 1'b0;
      timeout_error_q <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      rx_error_q      <= rx_error_d;
      timeout_error_q <= timeout_error_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign bus.rx_tready     = rx_tready_q;
  assign bus.inp_tdata     = word_q;
  assign bus.inp_tvalid    = inp_tvalid_q;
  assign bus.out_tready    = out_tready_q;
  assign bus.tx_tdata      = tx_tdata_q;
  assign bus.tx_tvalid     = tx_tvalid_q;
  assign bus.rx_error      = rx_error_q;
  assign bus.timeout_error = timeout_error_q;
  assign bus.drop_count    = drop_count_q;
  assign bus.dbg_rx_state  = rx_state_q;
  assign bus.dbg_tx_state  = {1'b0, tx_state_q};
endmodule
